fp_norm_round_pack: RTL

- Back end of the floating-point add/sub datapath; consumes the mantissa-stage result (sign, exponent, 26-bit mantissa, sticky/loss, operator).
- Normalises iteratively: one left shift per cycle.
- Rounds to nearest-even and packs an IEEE-754 single-precision word.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fp_norm_round_pack.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fp_norm_round_pack.sv
// Normalise / round-to-nearest-even / pack back end of the single-precision add/sub path.
// state | meaning
// IDLE  | waiting for a mantissa-stage result (in_ready=1)
// NORM  | one left shift per cycle until the hidden bit is set, or special-case exit
// ROUND | RNE increment of the fraction, carry into exponent, overflow detect
// DONE  | result and flags presented until out_ready
module fp_norm_round_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sign,
    input  logic                     operator,
    input  logic [EXP_W-1:0]         exp,
    input  logic [FRAC_W+2:0]        mantis,
    input  logic                     loss,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_W:0]    result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     inexact
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic                    op_q, op_d;
    logic [EXP_W-1:0]        exp_q, exp_d;
    logic [FRAC_W+2:0]       mant_q, mant_d;
    logic                    loss_q, loss_d;
    logic [EXP_W+FRAC_W:0]   result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inx_q, inx_d;

    logic                    rnd_g, rnd_r, rnd_lsb, rnd_up;
    logic [FRAC_W:0]         frac_sum;
    logic [EXP_W-1:0]        exp_rnd;

    assign rnd_g    = mant_q[1];
    assign rnd_r    = mant_q[0];
    assign rnd_lsb  = mant_q[2];
    assign rnd_up   = rnd_g & (rnd_r | loss_q | rnd_lsb);
    assign frac_sum = {1'b0, mant_q[FRAC_W+1:2]} + {{FRAC_W{1'b0}}, rnd_up};
    // A carry out of the fraction leaves an all-zero fraction and bumps the exponent.
    assign exp_rnd  = exp_q + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        op_d     = op_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        loss_d   = loss_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign;
                    op_d    = operator;
                    exp_d   = exp;
                    mant_d  = mantis;
                    loss_d  = loss;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inx_d   = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    // Exact cancellation of an effective subtraction yields +0.
                    result_d = {sign_q & ~op_q, {(EXP_W+FRAC_W){1'b0}}};
                    inx_d    = loss_q;
                    state_d  = DONE;
                end else if (exp_q == EXP_MAX) begin
                    result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                    ovf_d    = 1'b1;
                    state_d  = DONE;
                end else if ((exp_q == '0) || (!mant_q[FRAC_W+2] && (exp_q == EXP_ONE))) begin
                    result_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else if (mant_q[FRAC_W+2]) begin
                    state_d = ROUND;
                end else begin
                    mant_d = {mant_q[FRAC_W+1:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            ROUND: begin
                if (exp_rnd == EXP_MAX) begin
                    result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd, frac_sum[FRAC_W-1:0]};
                end
                inx_d   = rnd_g | rnd_r | loss_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            op_q     <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            loss_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            op_q     <= op_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            loss_q   <= loss_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    // Held low for the whole time reset is asserted, not just after the first edge.
    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule
